player_vertical_motion: RTL

PLAYER_VERTICAL_MOTION -- requirements
Module: player_vertical_motion

---
 rtl/player_vertical_motion.sv | 129 ++++++++++++
 1 files changed

// File: rtl/player_vertical_motion.sv
// Vertical motion of the player: lands on platform stops, falls or rises with gravity, dies at the limits.
// Optional macro VELOCITY_RAMP_EN: the step ramps 1..STEP_MAX instead of staying fixed at STEP_MAX.
module player_vertical_motion #(
    parameter int STEP_MAX     = 4,
    parameter int START_HEIGHT = 120,
    parameter int CEIL_LIMIT   = 420
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       dir,
    input  logic [2:0] lines,
    output logic [8:0] height,
    output logic       landed,
    output logic       is_dead
);

    typedef enum logic [1:0] {ST_LANDED, ST_FALLING, ST_DEAD} state_t;

    localparam logic [8:0] FLOOR_H  = 9'd120;
    localparam logic [8:0] UP_MID_H = 9'd180;
    localparam logic [8:0] DN_MID_H = 9'd240;
    localparam logic [8:0] CEIL_H   = 9'd300;

    localparam logic signed [9:0] FLOOR_S  = 10'sd120;
    localparam logic signed [9:0] UP_MID_S = 10'sd180;
    localparam logic signed [9:0] DN_MID_S = 10'sd240;
    localparam logic signed [9:0] CEIL_S   = 10'sd300;
    localparam logic signed [9:0] LIMIT_S  = 10'(CEIL_LIMIT);

    state_t            r_state, w_state_nxt;
    logic [8:0]        r_height, w_height_nxt;
    logic              r_dir;
    logic [9:0]        w_step;
    logic signed [9:0] w_cand;
    logic              w_support;
    logic              w_move;

`ifdef VELOCITY_RAMP_EN
    logic [9:0] r_speed, w_speed_nxt;

    // The ramp restarts whenever motion begins or reverses direction.
    always_comb begin
        w_step      = (r_state == ST_FALLING && dir == r_dir) ? r_speed : 10'd1;
        w_speed_nxt = (w_step >= 10'(STEP_MAX)) ? 10'(STEP_MAX) : w_step + 10'd1;
    end
`else
    assign w_step = 10'(STEP_MAX);
`endif

    always_comb begin
        case (r_height)
            FLOOR_H:            w_support = lines[0];
            UP_MID_H, DN_MID_H: w_support = lines[1];
            CEIL_H:             w_support = lines[2];
            default:            w_support = 1'b0;
        endcase
    end

    assign w_move = tick && ((r_state == ST_FALLING) ||
                             (r_state == ST_LANDED && (dir != r_dir || !w_support)));

    // Signed 10-bit candidate so that an overshoot below zero is still visible.
    assign w_cand = dir ? $signed({1'b0, r_height} + w_step)
                        : $signed({1'b0, r_height} - w_step);

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_height_nxt = r_height;
        if (w_move) begin
            if (!dir) begin
                if (lines[1] && r_height > DN_MID_H && DN_MID_S >= w_cand) begin
                    w_height_nxt = DN_MID_H;
                    w_state_nxt  = ST_LANDED;
                end else if (lines[0] && r_height > FLOOR_H && FLOOR_S >= w_cand) begin
                    w_height_nxt = FLOOR_H;
                    w_state_nxt  = ST_LANDED;
                end else if (w_cand <= 10'sd0) begin
                    w_height_nxt = 9'd0;
                    w_state_nxt  = ST_DEAD;
                end else begin
                    w_height_nxt = w_cand[8:0];
                    w_state_nxt  = ST_FALLING;
                end
            end else begin
                if (lines[1] && r_height < UP_MID_H && UP_MID_S <= w_cand) begin
                    w_height_nxt = UP_MID_H;
                    w_state_nxt  = ST_LANDED;
                end else if (lines[2] && r_height < CEIL_H && CEIL_S <= w_cand) begin
                    w_height_nxt = CEIL_H;
                    w_state_nxt  = ST_LANDED;
                end else if (w_cand >= LIMIT_S) begin
                    w_height_nxt = 9'(CEIL_LIMIT);
                    w_state_nxt  = ST_DEAD;
                end else begin
                    w_height_nxt = w_cand[8:0];
                    w_state_nxt  = ST_FALLING;
                end
            end
        end
    end

    // NOTE: synchronous active-low reset inside the clocked block; non-blocking assignments for all state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_LANDED;
            r_height <= 9'(START_HEIGHT);
            r_dir    <= 1'b0;
`ifdef VELOCITY_RAMP_EN
            r_speed  <= 10'd1;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_height <= w_height_nxt;
            if (w_move) begin
                r_dir <= dir;
`ifdef VELOCITY_RAMP_EN
                r_speed <= w_speed_nxt;
`endif
            end
        end
    end

    assign height  = r_height;
    assign landed  = (r_state == ST_LANDED);
    assign is_dead = (r_state == ST_DEAD);

endmodule
